// File: rtl/pdp6_timing_pkg.sv
// Shared timing definitions for the pulse chain sequencer and the callers that build its delay vector.
package pdp6_timing_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam int unsigned CLK_NS = 10;
  localparam int unsigned STG_W  = 3;

  // Nanoseconds to whole clock cycles, rounded up.
  function automatic int unsigned ns2cyc(input int unsigned ns);
    return (ns + CLK_NS - 1) / CLK_NS;
  endfunction

endpackage

// File: rtl/pcs_timer.sv
// Stage delay counter: counts cycles since the stage began and flags the cycle before the pulse is due.
module pcs_timer #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_run,
  input  logic          i_load,
  input  logic [CW-1:0] i_lim,
  output logic          o_expire_c
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_lim;
  logic [CW-1:0] w_cur;
  logic [CW-1:0] w_nxt;

  // A zero delay behaves as one cycle; a load makes this cycle the first of the stage.
  assign w_lim      = (i_lim == '0) ? CW'(1) : i_lim;
  assign w_cur      = i_load ? '0 : r_cnt;
  assign w_nxt      = w_cur + CW'(1);
  assign o_expire_c = i_run && (w_nxt == w_lim);

  always_ff @(posedge clk) begin
    if (reset || !i_run || o_expire_c) r_cnt <= '0;
    else                               r_cnt <= w_nxt;
  end

endmodule

// File: rtl/pulse_chain_seq.sv
// Sequences NSTAGE timed pulses from one start, with optional ack holds between stages.
module pulse_chain_seq
  import pdp6_timing_pkg::*;
#(
  parameter int unsigned       NSTAGE   = 4,
  parameter int unsigned       CW       = 8,
  parameter logic [NSTAGE-1:0] WAITMASK = '0,
  parameter bit                RETRIG   = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 ack,
  input  logic [NSTAGE*CW-1:0] dly_cfg,
  output logic [NSTAGE-1:0]    p,
  output logic                 done,
  output logic                 busy,
  output logic [STG_W-1:0]     stg,
  output logic                 waiting,
  output logic                 ovr
);

  localparam int unsigned      IW   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [STG_W-1:0] LAST = STG_W'(NSTAGE - 1);

  state_t                r_state, w_next;
  logic [STG_W-1:0]      r_stg, w_stg_n, w_cur;
  logic [NSTAGE*CW-1:0]  r_cfg, w_cfg_src;
  logic [NSTAGE-1:0]     r_p, w_p_n;
  logic [STG_W-1:0]      r_stg_o, w_stg_o_n;
  logic                  r_done, r_busy, r_waiting, r_ovr;
  logic                  w_done_n, w_busy_n, w_waiting_n;
  logic                  w_active, w_launch, w_ack_ok, w_ovr, w_expire;
  logic [CW-1:0]         w_lims [NSTAGE];
  logic [CW-1:0]         w_lim;

  // Delays of a fresh launch come straight from the inputs; the latch only holds from the next cycle.
  assign w_cfg_src = w_launch ? dly_cfg : r_cfg;
  for (genvar g = 0; g < NSTAGE; g++) begin : g_lim
    assign w_lims[g] = w_cfg_src[g*CW +: CW];
  end
  assign w_lim = w_lims[w_cur[IW-1:0]];

  pcs_timer #(.CW(CW)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_run      (w_active),
    .i_load     (w_launch || w_ack_ok),
    .i_lim      (w_lim),
    .o_expire_c (w_expire)
  );

  // Which stage runs this cycle, and whether it is freshly begun.
  always_comb begin
    w_active = 1'b0;
    w_launch = 1'b0;
    w_ack_ok = 1'b0;
    w_ovr    = 1'b0;
    w_cur    = r_stg;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_launch = 1'b1;
          w_active = 1'b1;
          w_cur    = '0;
        end
      end
      ST_COUNT: begin
        w_active = 1'b1;
        if (start && RETRIG) begin
          w_launch = 1'b1;
          w_cur    = '0;
        end else if (start) begin
          w_ovr = 1'b1;
        end
      end
      ST_WAIT: begin
        if (start && RETRIG) begin
          w_launch = 1'b1;
          w_active = 1'b1;
          w_cur    = '0;
        end else begin
          w_ovr = start;
          // The pulse cycle of the held stage is still visible on p; ack is not taken then.
          if (ack && (r_p == '0)) begin
            w_ack_ok = 1'b1;
            w_active = 1'b1;
            w_cur    = STG_W'(r_stg + STG_W'(1));
          end
        end
      end
      default: ;
    endcase
    if (abort) begin
      w_active = 1'b0;
      w_launch = 1'b0;
      w_ack_ok = 1'b0;
      w_ovr    = 1'b0;
    end
  end

  always_comb begin
    w_next    = abort ? ST_IDLE : r_state;
    w_stg_n   = abort ? '0 : r_stg;
    w_p_n     = '0;
    w_done_n  = 1'b0;
    if (w_active) begin
      if (w_expire) begin
        w_p_n = NSTAGE'(1) << w_cur;
        if (w_cur == LAST) begin
          w_next   = ST_IDLE;
          w_stg_n  = '0;
          w_done_n = 1'b1;
        end else if (WAITMASK[w_cur[IW-1:0]]) begin
          w_next  = ST_WAIT;
          w_stg_n = w_cur;
        end else begin
          w_next  = ST_COUNT;
          w_stg_n = STG_W'(w_cur + STG_W'(1));
        end
      end else begin
        w_next  = ST_COUNT;
        w_stg_n = w_cur;
      end
    end
    w_busy_n    = (w_next != ST_IDLE) || w_done_n;
    w_stg_o_n   = w_busy_n ? w_cur : '0;
    w_waiting_n = (r_state == ST_WAIT) && (w_next == ST_WAIT) && !w_ack_ok && !w_launch;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_stg     <= '0;
      r_cfg     <= '0;
      r_p       <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
      r_stg_o   <= '0;
      r_waiting <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_stg     <= w_stg_n;
      if (w_launch) r_cfg <= dly_cfg;
      r_p       <= w_p_n;
      r_done    <= w_done_n;
      r_busy    <= w_busy_n;
      r_stg_o   <= w_stg_o_n;
      r_waiting <= w_waiting_n;
      r_ovr     <= w_ovr;
    end
  end

  assign p       = r_p;
  assign done    = r_done;
  assign busy    = r_busy;
  assign stg     = r_stg_o;
  assign waiting = r_waiting;
  assign ovr     = r_ovr;

endmodule

// File: tb/tb_pulse_chain_seq.sv
// Scoreboard bench: two sequencers (RETRIG 0 and 1) share stimulus and are checked against a deadline model.
module tb_pulse_chain_seq;
  import pdp6_timing_pkg::*;

  localparam logic [3:0] WM = 4'b0010;

  logic        clk = 1'b0;
  logic        reset, start, abort, ack;
  logic [31:0] dly_cfg;
  logic [3:0]  o_p    [2];
  logic [2:0]  o_stg  [2];
  logic        o_done [2];
  logic        o_busy [2];
  logic        o_wait [2];
  logic        o_ovr  [2];

  always #5 clk = ~clk;

  pulse_chain_seq #(.NSTAGE(4), .CW(8), .WAITMASK(WM), .RETRIG(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack), .dly_cfg(dly_cfg),
    .p(o_p[0]), .done(o_done[0]), .busy(o_busy[0]), .stg(o_stg[0]), .waiting(o_wait[0]), .ovr(o_ovr[0]));

  pulse_chain_seq #(.NSTAGE(4), .CW(8), .WAITMASK(WM), .RETRIG(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .ack(ack), .dly_cfg(dly_cfg),
    .p(o_p[1]), .done(o_done[1]), .busy(o_busy[1]), .stg(o_stg[1]), .waiting(o_wait[1]), .ovr(o_ovr[1]));

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic       done;
    logic       ovr;
  } ev_t;

  ev_t sbq [2][$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  bit  chk_en = 1'b0;

  // Reference model: the chain is a current stage plus the cycle its pulse is due.
  bit   m_on [2];
  bit   m_wt [2];
  int   m_stg[2];
  int   m_dl [2];
  int   m_pw [2];
  int   m_d  [2][4];
  bit   nx_busy[2], cu_busy[2];
  bit   nx_wait[2], cu_wait[2];
  int   nx_stg [2], cu_stg [2];

  function automatic int dm(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_step(input int k, input bit s, input bit a, input bit ak, input bit rs,
                            input logic [31:0] cfg);
    bit   ov = 1'b0;
    bit   launched = 1'b0;
    ev_t  e;
    if (rs) begin
      m_on[k] = 1'b0;
      m_wt[k] = 1'b0;
    end else begin
      if (m_on[k] && !m_wt[k] && m_dl[k] == cyc) begin
        if (m_stg[k] == 3) m_on[k] = 1'b0;
        else if (WM[m_stg[k]]) begin m_wt[k] = 1'b1; m_pw[k] = cyc; end
        else begin m_stg[k]++; m_dl[k] = cyc + dm(m_d[k][m_stg[k]]); end
      end
      if (a) begin
        m_on[k] = 1'b0;
      end else begin
        if (s && (!m_on[k] || k == 1)) begin
          for (int i = 0; i < 4; i++) m_d[k][i] = int'(cfg[i*8 +: 8]);
          m_on[k] = 1'b1; m_wt[k] = 1'b0; m_stg[k] = 0;
          m_dl[k] = cyc + dm(m_d[k][0]);
          launched = 1'b1;
        end else if (s) begin
          ov = 1'b1;
        end
        if (!launched && ak && m_on[k] && m_wt[k] && cyc > m_pw[k]) begin
          m_wt[k] = 1'b0; m_stg[k]++;
          m_dl[k] = cyc + dm(m_d[k][m_stg[k]]);
        end
      end
    end
    e.cyc  = cyc + 1;
    e.p    = 4'b0;
    e.done = 1'b0;
    e.ovr  = ov;
    if (m_on[k] && !m_wt[k] && m_dl[k] == cyc + 1) begin
      e.p    = 4'(1 << m_stg[k]);
      e.done = (m_stg[k] == 3);
    end
    if (e.p != 4'b0 || e.ovr) sbq[k].push_back(e);
    nx_busy[k] = m_on[k];
    nx_wait[k] = m_on[k] && m_wt[k];
    nx_stg[k]  = m_on[k] ? m_stg[k] : 0;
  endtask

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", name, k, cyc, act, exp);
    end
  endtask

  // Monitor: pops due events whenever a pulse/ovr is shown or expected, and checks levels each cycle.
  ev_t mon_e;
  bit  mon_hit;
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        while (sbq[k].size() > 0 && sbq[k][0].cyc < cyc) begin
          total++; bad++;
          $display("FAIL missed_event dut%0d got=none want=cyc%0d", k, sbq[k][0].cyc);
          void'(sbq[k].pop_front());
        end
        mon_hit = (sbq[k].size() > 0) && (sbq[k][0].cyc == cyc);
        if (mon_hit) mon_e = sbq[k].pop_front();
        else begin mon_e.cyc = cyc; mon_e.p = 4'b0; mon_e.done = 1'b0; mon_e.ovr = 1'b0; end
        if (mon_hit || (o_p[k] !== 4'b0) || (o_done[k] !== 1'b0) || (o_ovr[k] !== 1'b0)) begin
          check("p",    k, 32'(o_p[k]),    32'(mon_e.p));
          check("done", k, 32'(o_done[k]), 32'(mon_e.done));
          check("ovr",  k, 32'(o_ovr[k]),  32'(mon_e.ovr));
        end
        check("busy",    k, 32'(o_busy[k]), 32'(cu_busy[k]));
        check("waiting", k, 32'(o_wait[k]), 32'(cu_wait[k]));
        check("stg",     k, 32'(o_stg[k]),  32'(cu_stg[k]));
      end
    end
  end

  task automatic tick(input bit s, input bit a, input bit ak, input bit rs, input logic [31:0] cfg);
    start = s; abort = a; ack = ak; reset = rs; dly_cfg = cfg;
    for (int k = 0; k < 2; k++) model_step(k, s, a, ak, rs, cfg);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      cu_busy[k] = nx_busy[k];
      cu_wait[k] = nx_wait[k];
      cu_stg[k]  = nx_stg[k];
    end
  endtask

  logic [31:0] cfg_a, cfg_b, cfg;

  task automatic idle_to(input int t, input logic [31:0] c);
    while (cyc < t) tick(1'b0, 1'b0, 1'b0, 1'b0, c);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_on[k] = 1'b0; m_wt[k] = 1'b0; m_stg[k] = 0; m_dl[k] = 0; m_pw[k] = 0;
      cu_busy[k] = 1'b0; cu_wait[k] = 1'b0; cu_stg[k] = 0;
    end
    // D0=3 D1=5 D2=1 D3=2 built from nanosecond figures.
    cfg_a = {8'(ns2cyc(15)), 8'(ns2cyc(10)), 8'(ns2cyc(41)), 8'(ns2cyc(25))};
    cfg_b = {8'd2, 8'd1, 8'd5, 8'd0};
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, cfg_a);
    chk_en = 1'b1;
    // Full chain with ack hold, then relaunch in the done cycle.
    idle_to(10, cfg_a); tick(1'b1, 1'b0, 1'b0, 1'b0, cfg_a);
    idle_to(12, cfg_a); tick(1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    idle_to(18, cfg_a); tick(1'b0, 1'b0, 1'b1, 1'b0, cfg_a);
    idle_to(25, cfg_a); tick(1'b0, 1'b0, 1'b1, 1'b0, cfg_a);
    idle_to(28, cfg_a); tick(1'b1, 1'b0, 1'b0, 1'b0, cfg_a);
    idle_to(43, cfg_a); tick(1'b0, 1'b0, 1'b1, 1'b0, cfg_a);
    // Abort while waiting, later ack ignored.
    idle_to(60, cfg_a); tick(1'b1, 1'b0, 1'b0, 1'b0, cfg_a);
    idle_to(71, cfg_a); tick(1'b0, 1'b1, 1'b0, 1'b0, cfg_a);
    idle_to(75, cfg_a); tick(1'b0, 1'b0, 1'b1, 1'b0, cfg_a);
    // Zero first delay, then start while busy (ovr / retrigger), start+abort together.
    idle_to(80, cfg_b); tick(1'b1, 1'b0, 1'b0, 1'b0, cfg_b);
    idle_to(100, cfg_a); tick(1'b1, 1'b0, 1'b0, 1'b0, cfg_a);
    idle_to(105, cfg_a); tick(1'b1, 1'b0, 1'b0, 1'b0, cfg_a);
    idle_to(110, cfg_a); tick(1'b1, 1'b1, 1'b0, 1'b0, cfg_a);
    // Reset during COUNT, stray ack before it.
    idle_to(120, cfg_a); tick(1'b1, 1'b0, 1'b0, 1'b0, cfg_a);
    idle_to(122, cfg_a); tick(1'b0, 1'b0, 1'b1, 1'b0, cfg_a);
    idle_to(124, cfg_a); tick(1'b0, 1'b0, 1'b0, 1'b1, cfg_a);
    idle_to(130, cfg_a); tick(1'b1, 1'b0, 1'b0, 1'b0, cfg_a);
    idle_to(140, cfg_a); tick(1'b0, 1'b0, 1'b1, 1'b0, cfg_a);
    idle_to(150, cfg_a);
    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++)
        cfg[i*8 +: 8] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 6));
      tick(($urandom_range(0, 11) == 0), ($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 599) == 0), cfg);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, cfg_a);
    for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, cfg_a);
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) check("queue_empty", k, 32'(sbq[k].size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
